// File: rtl/fft_pkg.sv
// Shared definitions for the streaming 4-point FFT: frame size and FSM state encoding.
package fft_pkg;
   localparam int FFT_N = 4;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      S1     = 2'd1,
      S2     = 2'd2,
      UNLOAD = 2'd3
   } state_t;
endpackage

// File: rtl/fft4_stream_if.sv
// Sample-in / bin-out stream bundle for fft4_stream; master is the traffic source, slave is the FFT.
interface fft4_stream_if #(
   parameter int DW = 2
);
   localparam int OW = DW + 2;

   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_re;
   logic signed [DW-1:0] in_im;
   logic                 inv;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [OW-1:0] out_re;
   logic signed [OW-1:0] out_im;
   logic [1:0]           out_idx;
   logic                 out_last;

   modport master (
      output in_valid, in_re, in_im, inv, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_re, in_im, inv, out_ready,
      output in_ready, out_valid, out_re, out_im, out_idx, out_last
   );
endinterface

// File: rtl/radix2_bfly.sv
// Combinational complex radix-2 butterfly: sum and difference, one bit of growth.
module radix2_bfly #(
   parameter int W = 2
) (
   input  logic [W-1:0] i_a_re,
   input  logic [W-1:0] i_a_im,
   input  logic [W-1:0] i_b_re,
   input  logic [W-1:0] i_b_im,
   output logic [W:0]   o_sum_re,
   output logic [W:0]   o_sum_im,
   output logic [W:0]   o_dif_re,
   output logic [W:0]   o_dif_im
);
   logic [W:0] w_a_re, w_a_im, w_b_re, w_b_im;

   assign w_a_re = {i_a_re[W-1], i_a_re};
   assign w_a_im = {i_a_im[W-1], i_a_im};
   assign w_b_re = {i_b_re[W-1], i_b_re};
   assign w_b_im = {i_b_im[W-1], i_b_im};

   assign o_sum_re = w_a_re + w_b_re;
   assign o_sum_im = w_a_im + w_b_im;
   assign o_dif_re = w_a_re - w_b_re;
   assign o_dif_im = w_a_im - w_b_im;
endmodule

// File: rtl/fft4_stream.sv
// Streaming 4-point radix-2 DIT FFT: load 4 samples, two registered butterfly stages, unload 4 bins.
module fft4_stream
   import fft_pkg::*;
#(
   parameter int DW = 2
) (
   input logic         clk,
   input logic         rst_n,
   fft4_stream_if.slave bus
);
   localparam int OW = DW + 2;

   typedef struct packed { logic signed [DW-1:0] re; logic signed [DW-1:0] im; } smp_t;
   typedef struct packed { logic signed [DW:0]   re; logic signed [DW:0]   im; } s1_t;
   typedef struct packed { logic signed [OW-1:0] re; logic signed [OW-1:0] im; } bin_t;

   state_t     r_state, w_next;
   smp_t       r_x   [FFT_N];
   bin_t       r_bin [FFT_N];
   logic [1:0] r_cnt;
   logic [1:0] r_idx;
   logic       r_inv;
   s1_t        r_a, r_b, r_c, r_d;
   s1_t        w_a, w_b, w_c, w_d;
   bin_t       w_x0, w_x2, w_bmj, w_bpj;
   logic       w_in_ready, w_out_valid, w_in_fire, w_out_fire;

   radix2_bfly #(.W(DW)) u_bfly_02 (
      .i_a_re(r_x[0].re), .i_a_im(r_x[0].im), .i_b_re(r_x[2].re), .i_b_im(r_x[2].im),
      .o_sum_re(w_a.re), .o_sum_im(w_a.im), .o_dif_re(w_b.re), .o_dif_im(w_b.im)
   );

   radix2_bfly #(.W(DW)) u_bfly_13 (
      .i_a_re(r_x[1].re), .i_a_im(r_x[1].im), .i_b_re(r_x[3].re), .i_b_im(r_x[3].im),
      .o_sum_re(w_c.re), .o_sum_im(w_c.im), .o_dif_re(w_d.re), .o_dif_im(w_d.im)
   );

   radix2_bfly #(.W(DW + 1)) u_bfly_ac (
      .i_a_re(r_a.re), .i_a_im(r_a.im), .i_b_re(r_c.re), .i_b_im(r_c.im),
      .o_sum_re(w_x0.re), .o_sum_im(w_x0.im), .o_dif_re(w_x2.re), .o_dif_im(w_x2.im)
   );

   // Multiplying D by -j/+j is a re/im swap with one negated term.
   always_comb begin
      w_bmj.re = {r_b.re[DW], r_b.re} + {r_d.im[DW], r_d.im};
      w_bmj.im = {r_b.im[DW], r_b.im} - {r_d.re[DW], r_d.re};
      w_bpj.re = {r_b.re[DW], r_b.re} - {r_d.im[DW], r_d.im};
      w_bpj.im = {r_b.im[DW], r_b.im} + {r_d.re[DW], r_d.re};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= LOAD;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         LOAD: begin
            w_in_ready = 1'b1;
            if (bus.in_valid && (r_cnt == 2'(FFT_N - 1))) w_next = S1;
         end
         S1:     w_next = S2;
         S2:     w_next = UNLOAD;
         UNLOAD: begin
            w_out_valid = 1'b1;
            if (bus.out_ready && (r_idx == 2'(FFT_N - 1))) w_next = LOAD;
         end
         default: w_next = LOAD;
      endcase
   end

   assign w_in_fire  = bus.in_valid && w_in_ready;
   assign w_out_fire = bus.out_ready && w_out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FFT_N; i++) begin
            r_x[i]   <= '0;
            r_bin[i] <= '0;
         end
         r_cnt <= '0;
         r_idx <= '0;
         r_inv <= 1'b0;
         r_a   <= '0;
         r_b   <= '0;
         r_c   <= '0;
         r_d   <= '0;
      end else begin
         case (r_state)
            LOAD: if (w_in_fire) begin
               r_x[r_cnt].re <= bus.in_re;
               r_x[r_cnt].im <= bus.in_im;
               r_cnt         <= r_cnt + 2'd1;
               if (r_cnt == 2'd0) r_inv <= bus.inv;
            end
            S1: begin
               r_a <= w_a;
               r_b <= w_b;
               r_c <= w_c;
               r_d <= w_d;
            end
            S2: begin
               r_bin[0] <= w_x0;
               r_bin[2] <= w_x2;
               r_bin[1] <= r_inv ? w_bpj : w_bmj;
               r_bin[3] <= r_inv ? w_bmj : w_bpj;
            end
            UNLOAD: if (w_out_fire) r_idx <= r_idx + 2'd1;
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_re    = r_bin[r_idx].re;
   assign bus.out_im    = r_bin[r_idx].im;
   assign bus.out_idx   = r_idx;
   assign bus.out_last  = w_out_valid && (r_idx == 2'(FFT_N - 1));
endmodule

// File: tb/tb_fft4_stream.sv
// Directed bench for fft4_stream: known frames with hand-computed bins, backpressure and resets.
module tb_fft4_stream;
   localparam int DW = 2;
   localparam int OW = DW + 2;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fft4_stream_if #(.DW(DW)) bus ();

   fft4_stream #(.DW(DW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Present 4 samples; inv is flipped on samples 1..3 so only sample 0 should matter.
   task automatic send_frame(input int re[4], input int im[4], input logic inv0, input logic hold);
      int g;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_re    = DW'(re[i]);
         bus.in_im    = DW'(im[i]);
         bus.inv      = (i == 0) ? inv0 : ~inv0;
         g = 0;
         while (!bus.in_ready && g < 20) begin
            @(negedge clk);
            g++;
         end
         checks++;
         if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready sample%0d got %b want 1", i, bus.in_ready);
         end
         @(posedge clk);
      end
      #1;
      if (!hold) bus.in_valid = 1'b0;
   endtask

   // Collect 4 bins right after send_frame; optional 3-cycle stall while bin stall_idx is shown.
   task automatic recv_frame(input int ere[4], input int eim[4], input int stall_idx, input string nm);
      int n = 0, guard = 0, stall = 0, first = 0, last = 0;
      logic signed [OW-1:0] er, ei;
      bus.out_ready = 1'b1;
      while (n < 4 && guard < 40) begin
         @(negedge clk);
         guard++;
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_busy cycle%0d got %b want 0", nm, guard, bus.in_ready);
         end
         if (bus.out_valid === 1'b1) begin
            if (n == 0) begin
               first = guard;
               checks++;
               if (guard != 3) begin
                  errors++;
                  $display("FAIL %s latency got %0d want 3", nm, guard);
               end
            end
            er = OW'(ere[n]);
            ei = OW'(eim[n]);
            checks++;
            if ({bus.out_re, bus.out_im, bus.out_idx, bus.out_last} !== {er, ei, 2'(n), (n == 3)}) begin
               errors++;
               $display("FAIL %s bin%0d got re=%0d im=%0d idx=%0d last=%b want re=%0d im=%0d idx=%0d last=%b",
                        nm, n, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, er, ei, n, (n == 3));
            end
            if (n == stall_idx && stall < 3) begin
               bus.out_ready = 1'b0;
               stall++;
            end else begin
               bus.out_ready = 1'b1;
               last = guard;
               n++;
            end
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL %s timeout bins got %0d want 4", nm, n);
      end
      if (stall_idx < 0) begin
         checks++;
         if (last - first != 3) begin
            errors++;
            $display("FAIL %s consecutive span got %0d want 3", nm, last - first);
         end
      end
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL %s post_frame got valid=%b ready=%b want valid=0 ready=1", nm, bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, bus.in_ready} !==
          {1'b0, {OW{1'b0}}, {OW{1'b0}}, 2'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state got valid=%b re=%0d im=%0d idx=%0d last=%b ready=%b want 0 0 0 0 0 1",
                  bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, bus.in_ready);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_constant;
      send_frame('{1, 1, 1, 1}, '{0, 0, 0, 0}, 1'b0, 1'b0);
      recv_frame('{4, 0, 0, 0}, '{0, 0, 0, 0}, -1, "constant");
   endtask

   task automatic test_impulse;
      send_frame('{1, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0, 1'b0);
      recv_frame('{1, 1, 1, 1}, '{0, 0, 0, 0}, -1, "impulse");
   endtask

   task automatic test_shifted;
      send_frame('{0, 1, 0, 0}, '{0, 0, 0, 0}, 1'b0, 1'b0);
      recv_frame('{1, 0, -1, 0}, '{0, -1, 0, 1}, -1, "shifted_fwd");
   endtask

   task automatic test_inverse;
      send_frame('{0, 1, 0, 0}, '{0, 0, 0, 0}, 1'b1, 1'b0);
      recv_frame('{1, 0, -1, 0}, '{0, 1, 0, -1}, -1, "shifted_inv");
   endtask

   task automatic test_extremes;
      send_frame('{-2, -2, -2, -2}, '{-2, -2, -2, -2}, 1'b0, 1'b0);
      recv_frame('{-8, 0, 0, 0}, '{-8, 0, 0, 0}, -1, "extremes");
   endtask

   task automatic test_backpressure;
      send_frame('{0, 1, 0, 0}, '{0, 0, 0, 0}, 1'b0, 1'b0);
      recv_frame('{1, 0, -1, 0}, '{0, -1, 0, 1}, 1, "backpressure");
   endtask

   // in_valid stays high through S1/S2/UNLOAD; the following frame must start at sample 0.
   task automatic test_back_to_back;
      send_frame('{1, 1, 1, 1}, '{0, 0, 0, 0}, 1'b0, 1'b1);
      recv_frame('{4, 0, 0, 0}, '{0, 0, 0, 0}, -1, "inflight_hold");
      send_frame('{0, 1, 0, 0}, '{0, 0, 0, 0}, 1'b0, 1'b0);
      recv_frame('{1, 0, -1, 0}, '{0, -1, 0, 1}, -1, "after_hold");
   endtask

   task automatic test_reset_unload;
      int g = 0;
      send_frame('{0, 1, 0, 0}, '{0, 0, 0, 0}, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      do begin
         @(negedge clk);
         g++;
      end while (!(bus.out_valid === 1'b1 && bus.out_idx === 2'd2) && g < 20);
      checks++;
      if (g >= 20) begin
         errors++;
         $display("FAIL rst_unload reach_idx2 got timeout want idx2");
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, bus.in_ready} !==
          {1'b0, {OW{1'b0}}, {OW{1'b0}}, 2'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL rst_unload async got valid=%b re=%0d im=%0d idx=%0d last=%b ready=%b want 0 0 0 0 0 1",
                  bus.out_valid, bus.out_re, bus.out_im, bus.out_idx, bus.out_last, bus.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send_frame('{1, 0, 0, 0}, '{0, 0, 0, 0}, 1'b0, 1'b0);
      recv_frame('{1, 1, 1, 1}, '{0, 0, 0, 0}, -1, "rst_unload_fresh");
   endtask

   task automatic test_reset_load;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_re    = DW'(1);
         bus.in_im    = DW'(1);
         bus.inv      = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send_frame('{0, 1, 0, 0}, '{0, 0, 0, 0}, 1'b0, 1'b0);
      recv_frame('{1, 0, -1, 0}, '{0, -1, 0, 1}, -1, "rst_load_fresh");
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_re     = '0;
      bus.in_im     = '0;
      bus.inv       = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_constant();
      test_impulse();
      test_shifted();
      test_inverse();
      test_extremes();
      test_backpressure();
      test_back_to_back();
      test_reset_unload();
      test_reset_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
